// File: rtl/dwa_pkg.sv
// -----------------------------------------------------------------------------
// dwa_pkg
// Shared sizing helpers, default-width typedefs and modular pointer arithmetic
// for the DWA element selector (dwa_rotate, dwa_encoder).
// -----------------------------------------------------------------------------
package dwa_pkg;

    localparam int unsigned MASH_BW_DEF = 4;

    // Number of unit elements in the unary DAC for a bw-bit code.
    function automatic int unsigned n_elem(input int unsigned bw);
        return (32'd1 << bw) - 32'd1;
    endfunction

    // Pointer width able to address every element (at least one bit).
    function automatic int unsigned ptr_w(input int unsigned bw);
        int unsigned w;
        w = $clog2(n_elem(bw));
        return (w == 0) ? 32'd1 : w;
    endfunction

    localparam int unsigned N_ELEM_DEF = n_elem(MASH_BW_DEF);
    localparam int unsigned PTR_W_DEF  = ptr_w(MASH_BW_DEF);

    typedef logic [MASH_BW_DEF-1:0] count_t;
    typedef logic [PTR_W_DEF-1:0]   ptr_t;

    // (a + b) mod n for a < n, b <= n: a single conditional subtract suffices.
    function automatic int unsigned mod_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned n);
        int unsigned s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

    // (a - b) mod n for a < n, b <= n, computed as a + n - b then folded once.
    function automatic int unsigned mod_sub(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned n);
        int unsigned s;
        s = a + n - b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/dwa_rotate.sv
// -----------------------------------------------------------------------------
// dwa_rotate
// Combinational element selector: from the current pointer, element count and
// rotation direction, produce the unit-element enable vector and next pointer.
//   ptr_i        current rotation pointer (0..N_ELEM-1)
//   k_i          number of elements to enable (0..N_ELEM)
//   dir_i        0: ptr upward, 1: ptr-1 downward
//   en_c_o       enable vector, bit i drives element i
//   ptr_nxt_c_o  pointer after consuming k_i elements
// -----------------------------------------------------------------------------
module dwa_rotate
    import dwa_pkg::*;
#(
    parameter  int unsigned MASH_BW = 4,
    localparam int unsigned N_ELEM  = n_elem(MASH_BW),
    localparam int unsigned PTR_W   = ptr_w(MASH_BW)
) (
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic [MASH_BW-1:0] k_i,
    input  logic               dir_i,
    output logic [N_ELEM-1:0]  en_c_o,
    output logic [PTR_W-1:0]   ptr_nxt_c_o
);

    logic [31:0] ptr_u;
    logic [31:0] k_u;
    logic [31:0] top_u;

    assign ptr_u = 32'(ptr_i);
    assign k_u   = 32'(k_i);
    // Downward selection starts at the element just below the pointer.
    assign top_u = mod_sub(ptr_u, 32'd1, N_ELEM);

    // Element g is enabled when its circular distance from the start is below k.
    for (genvar g = 0; g < N_ELEM; g++) begin : g_sel
        assign en_c_o[g] = dir_i ? (mod_sub(top_u, 32'(g), N_ELEM) < k_u)
                                 : (mod_sub(32'(g), ptr_u, N_ELEM) < k_u);
    end

    assign ptr_nxt_c_o = dir_i ? PTR_W'(mod_sub(ptr_u, k_u, N_ELEM))
                               : PTR_W'(mod_add(ptr_u, k_u, N_ELEM));

endmodule

// File: rtl/dwa_encoder.sv
// -----------------------------------------------------------------------------
// dwa_encoder
// Data-weighted-averaging element selector downstream of mash11. Each signed
// MASH_BW-bit code becomes a unary enable vector whose position rotates so
// element mismatch is first-order shaped. One-cycle latency AXI-stream stage.
//   aclk / arst          clock, asynchronous active-high reset
//   s_axis_data_*        signed code in (tdata, tvalid, tready)
//   m_axis_data_*        N_ELEM-bit element enables out (tdata, tvalid, tready)
// Build option: define DWA_BIDIR_EN for bidirectional rotation (direction
// toggles every accepted sample); otherwise rotation is always upward.
// -----------------------------------------------------------------------------
module dwa_encoder
    import dwa_pkg::*;
#(
    parameter  int unsigned MASH_BW = 4,
    localparam int unsigned N_ELEM  = n_elem(MASH_BW),
    localparam int unsigned PTR_W   = ptr_w(MASH_BW)
) (
    input  logic               aclk,
    input  logic               arst,
    input  logic [MASH_BW-1:0] s_axis_data_tdata,
    input  logic               s_axis_data_tvalid,
    output logic               s_axis_data_tready,
    output logic [N_ELEM-1:0]  m_axis_data_tdata,
    output logic               m_axis_data_tvalid,
    input  logic               m_axis_data_tready
);

    logic [N_ELEM-1:0]  tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               dir_q, dir_d;

    logic [MASH_BW-1:0] k_c;
    logic               accept_c;
    logic [N_ELEM-1:0]  en_c;
    logic [PTR_W-1:0]   ptr_nxt_c;

    // Offset-binary count: adding 2**(MASH_BW-1) to a two's complement code flips its MSB.
    assign k_c = {~s_axis_data_tdata[MASH_BW-1], s_axis_data_tdata[MASH_BW-2:0]};

    assign s_axis_data_tready = !tvalid_q || m_axis_data_tready;
    assign accept_c           = s_axis_data_tvalid && s_axis_data_tready;

    dwa_rotate #(
        .MASH_BW (MASH_BW)
    ) u_rotate (
        .ptr_i       (ptr_q),
        .k_i         (k_c),
        .dir_i       (dir_q),
        .en_c_o      (en_c),
        .ptr_nxt_c_o (ptr_nxt_c)
    );

    // Next-state: load on accept, drop valid once consumed, otherwise hold.
    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        ptr_d    = ptr_q;
        dir_d    = dir_q;
        if (accept_c) begin
            tdata_d  = en_c;
            tvalid_d = 1'b1;
            ptr_d    = ptr_nxt_c;
`ifdef DWA_BIDIR_EN
            dir_d    = !dir_q;
`else
            dir_d    = 1'b0;
`endif
        end else if (m_axis_data_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            ptr_q    <= '0;
            dir_q    <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            ptr_q    <= ptr_d;
            dir_q    <= dir_d;
        end
    end

    assign m_axis_data_tdata  = tdata_q;
    assign m_axis_data_tvalid = tvalid_q;

endmodule

// File: tb/tb_dwa_encoder.sv
`timescale 1ns/1ps
// Self-checking bench for dwa_encoder with a cycle-level behavioural model.
module tb_dwa_encoder;

    localparam int MASH_BW = 4;
    localparam int N_ELEM  = 15;
    localparam int IDX_W   = 4;
    localparam int HALF    = 8;

    logic                aclk = 1'b0;
    logic                arst;
    logic [MASH_BW-1:0]  s_tdata;
    logic                s_tvalid;
    logic                s_tready;
    logic [N_ELEM-1:0]   m_tdata;
    logic                m_tvalid;
    logic                m_tready;

    always #5 aclk = ~aclk;

    dwa_encoder #(.MASH_BW(MASH_BW)) dut (
        .aclk               (aclk),
        .arst               (arst),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid),
        .m_axis_data_tready (m_tready)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    int                mdl_ptr;
    bit                mdl_dir;
    bit                exp_valid;
    logic [N_ELEM-1:0] exp_data;
    int                exp_k;
    bit                exp_ready;
    logic              obs_ready;

    // Enable set: k consecutive elements walking up from p, or down from p-1.
    function automatic logic [N_ELEM-1:0] ref_vec(input int k, input int p, input bit d);
        logic [N_ELEM-1:0] v;
        logic [IDX_W-1:0]  idx;
        v = '0;
        for (int j = 0; j < k; j++) begin
            if (d) idx = IDX_W'((p - 1 - j + 2 * N_ELEM) % N_ELEM);
            else   idx = IDX_W'((p + j) % N_ELEM);
            v[idx] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_reset();
        mdl_ptr   = 0;
        mdl_dir   = 1'b0;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_k     = 0;
    endtask

    // One clock: drive at negedge, predict, let the edge happen, settle 1ns.
    task automatic cycle(input bit valid, input int x, input bit mready);
        int k;
        @(negedge aclk);
        s_tvalid = valid;
        s_tdata  = MASH_BW'(x);
        m_tready = mready;
        #1;
        obs_ready = s_tready;
        exp_ready = !exp_valid || mready;
        k = x + HALF;
        if (valid && exp_ready) begin
            exp_data  = ref_vec(k, mdl_ptr, mdl_dir);
            exp_valid = 1'b1;
            exp_k     = k;
            if (mdl_dir) mdl_ptr = (mdl_ptr - k + N_ELEM) % N_ELEM;
            else         mdl_ptr = (mdl_ptr + k) % N_ELEM;
`ifdef DWA_BIDIR_EN
            mdl_dir = !mdl_dir;
`endif
        end else if (mready) begin
            exp_valid = 1'b0;
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b1; s_tvalid = 1'b1; s_tdata = '0; m_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        n_vec++;
        if (m_tdata !== 15'h0000) begin
            n_err++; $display("FAIL reset_tdata: got %h want %h", m_tdata, 15'h0000);
        end
        n_vec++;
        if (m_tvalid !== 1'b0) begin
            n_err++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid);
        end
        @(negedge aclk);
        s_tvalid = 1'b0;
        arst = 1'b0;
        #1;
        n_vec++;
        if (s_tready !== 1'b1) begin
            n_err++; $display("FAIL reset_tready: got %b want 1", s_tready);
        end
        model_reset();
    endtask

    task automatic test_rotation();
        logic [N_ELEM-1:0] tbl [6];
        tbl = '{15'h0007, 15'h0038, 15'h01C0, 15'h0E00, 15'h7000, 15'h0007};
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, -5, 1'b1);
            n_vec++;
            if (m_tvalid !== 1'b1 || m_tdata !== exp_data) begin
                n_err++; $display("FAIL rotation_model[%0d]: got v=%b %h want v=1 %h", i, m_tvalid, m_tdata, exp_data);
            end
`ifndef DWA_BIDIR_EN
            n_vec++;
            if (m_tdata !== tbl[i]) begin
                n_err++; $display("FAIL rotation_const[%0d]: got %h want %h", i, m_tdata, tbl[i]);
            end
`endif
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 1, 1'b1);     // k=9 moves the pointer 3 -> 12
        n_vec++;
        if (m_tdata !== exp_data) begin
            n_err++; $display("FAIL wrap_preload: got %h want %h", m_tdata, exp_data);
        end
        cycle(1'b1, -3, 1'b1);    // k=5 across the top of the vector
        n_vec++;
        if (m_tdata !== exp_data) begin
            n_err++; $display("FAIL wrap_model: got %h want %h", m_tdata, exp_data);
        end
`ifndef DWA_BIDIR_EN
        n_vec++;
        if (m_tdata !== 15'h7003) begin
            n_err++; $display("FAIL wrap_const: got %h want %h", m_tdata, 15'h7003);
        end
`endif
        cycle(1'b1, -7, 1'b1);    // single element shows the wrapped pointer
        n_vec++;
        if (m_tdata !== exp_data) begin
            n_err++; $display("FAIL wrap_ptr_model: got %h want %h", m_tdata, exp_data);
        end
`ifndef DWA_BIDIR_EN
        n_vec++;
        if (m_tdata !== 15'h0004) begin
            n_err++; $display("FAIL wrap_ptr_const: got %h want %h", m_tdata, 15'h0004);
        end
`endif
    endtask

    task automatic test_extremes();
        cycle(1'b1, -8, 1'b1);
        n_vec++;
        if (m_tvalid !== 1'b1 || m_tdata !== 15'h0000) begin
            n_err++; $display("FAIL k0: got v=%b %h want v=1 %h", m_tvalid, m_tdata, 15'h0000);
        end
        cycle(1'b1, -7, 1'b1);
        n_vec++;
        if (m_tdata !== exp_data) begin
            n_err++; $display("FAIL k0_ptr: got %h want %h", m_tdata, exp_data);
        end
        cycle(1'b1, 7, 1'b1);
        n_vec++;
        if (m_tdata !== 15'h7FFF) begin
            n_err++; $display("FAIL kfull: got %h want %h", m_tdata, 15'h7FFF);
        end
        cycle(1'b1, -7, 1'b1);
        n_vec++;
        if (m_tdata !== exp_data) begin
            n_err++; $display("FAIL kfull_ptr: got %h want %h", m_tdata, exp_data);
        end
    endtask

    task automatic test_stall();
        logic [N_ELEM-1:0] held;
        cycle(1'b0, 0, 1'b1);
        n_vec++;
        if (m_tvalid !== 1'b0) begin
            n_err++; $display("FAIL stall_drain: got v=%b want 0", m_tvalid);
        end
        cycle(1'b1, -5, 1'b0);
        held = exp_data;
        n_vec++;
        if (obs_ready !== 1'b1 || m_tvalid !== 1'b1 || m_tdata !== held) begin
            n_err++; $display("FAIL stall_first: got rdy=%b v=%b %h want rdy=1 v=1 %h", obs_ready, m_tvalid, m_tdata, held);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2, 1'b0);
            n_vec++;
            if (obs_ready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== held) begin
                n_err++; $display("FAIL stall_hold[%0d]: got rdy=%b v=%b %h want rdy=0 v=1 %h", i, obs_ready, m_tvalid, m_tdata, held);
            end
        end
        cycle(1'b1, 2, 1'b1);
        n_vec++;
        if (obs_ready !== 1'b1 || m_tdata !== exp_data) begin
            n_err++; $display("FAIL stall_release: got rdy=%b %h want rdy=1 %h", obs_ready, m_tdata, exp_data);
        end
        cycle(1'b0, 0, 1'b1);
        n_vec++;
        if (m_tvalid !== 1'b0) begin
            n_err++; $display("FAIL stall_empty: got v=%b want 0", m_tvalid);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 3, 1'b0);
        @(negedge aclk);
        s_tvalid = 1'b0;
        arst = 1'b1;
        #1;
        n_vec++;
        if (m_tvalid !== 1'b0 || m_tdata !== 15'h0000) begin
            n_err++; $display("FAIL midreset_clear: got v=%b %h want v=0 %h", m_tvalid, m_tdata, 15'h0000);
        end
        @(negedge aclk);
        arst = 1'b0;
        model_reset();
        cycle(1'b1, -5, 1'b1);
        n_vec++;
        if (m_tvalid !== 1'b1 || m_tdata !== 15'h0007) begin
            n_err++; $display("FAIL midreset_restart: got v=%b %h want v=1 %h", m_tvalid, m_tdata, 15'h0007);
        end
    endtask

`ifdef DWA_BIDIR_EN
    task automatic test_bidir();
        @(negedge aclk);
        arst = 1'b1; s_tvalid = 1'b0;
        @(negedge aclk);
        arst = 1'b0;
        model_reset();
        cycle(1'b1, -5, 1'b1);
        n_vec++;
        if (m_tdata !== 15'h0007) begin
            n_err++; $display("FAIL bidir_up: got %h want %h", m_tdata, 15'h0007);
        end
        cycle(1'b1, -7, 1'b1);
        n_vec++;
        if (m_tdata !== 15'h0004) begin
            n_err++; $display("FAIL bidir_down: got %h want %h", m_tdata, 15'h0004);
        end
    endtask
`endif

    task automatic test_random();
        bit v;
        bit r;
        int x;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            x = int'($urandom_range(0, 15)) - HALF;
            cycle(v, x, r);
            n_vec++;
            if (obs_ready !== exp_ready) begin
                n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", i, obs_ready, exp_ready);
            end
            n_vec++;
            if (m_tvalid !== exp_valid) begin
                n_err++; $display("FAIL rand_valid[%0d]: got %b want %b", i, m_tvalid, exp_valid);
            end
            if (exp_valid) begin
                n_vec++;
                if (m_tdata !== exp_data) begin
                    n_err++; $display("FAIL rand_data[%0d]: got %h want %h", i, m_tdata, exp_data);
                end
                n_vec++;
                if ($countones(m_tdata) != exp_k) begin
                    n_err++; $display("FAIL rand_popcount[%0d]: got %0d want %0d", i, $countones(m_tdata), exp_k);
                end
            end
        end
    endtask

    initial begin
        arst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
        model_reset();
        test_reset();
        test_rotation();
        test_wrap();
        test_extremes();
        test_stall();
        test_reset_mid();
`ifdef DWA_BIDIR_EN
        test_bidir();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
